// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial receive sequencer.
package serial_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned           SYNC_W_DEF    = 8;
    localparam logic [SYNC_W_DEF-1:0] SYNC_WORD_DEF = 8'hA5;

    // Width needed to hold a count from 0 up to and including n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_frame_ctrl_sync_detect.sv
// Sync-word hunter: serial history register plus MSB-first comparator.
module sync_detect
    import serial_pkg::*;
#(
    parameter int unsigned       SYNC_W    = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SYNC_WORD_DEF)
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic tick,
    input  logic clr,
    output logic match
);

    // Only SYNC_W-1 history bits are kept: the oldest bit of a full-width
    // register is shifted out before it could ever take part in a compare.
    logic [SYNC_W-2:0] hist_q;
    logic [SYNC_W-2:0] hist_d;
    logic [SYNC_W-1:0] window;

    always_comb begin
        window = {hist_q, din};
        match  = tick && (window == SYNC_WORD);
        hist_d = hist_q;
        if (clr) begin
            hist_d = '0;
        end else if (tick) begin
            hist_d = window[SYNC_W-2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/serial_frame_ctrl.sv
// Receive-side frame sequencer: sync hunt, payload shift gating, capture
// strobe and a valid/ack handshake with sticky overrun reporting.
module serial_frame_ctrl
    import serial_pkg::*;
#(
    parameter int unsigned       NDATA     = 128,
    parameter int unsigned       SYNC_W    = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SYNC_WORD_DEF)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           din,
    input  logic                           bit_tick,
    input  logic                           frame_ack,
    input  logic                           clr_ovr,
    output logic                           shift_ena,
    output logic                           capture,
    output logic                           frame_valid,
    output logic                           overrun,
    output logic                           busy,
    output logic [cnt_width(NDATA)-1:0]    bit_cnt
);

    localparam int unsigned    CW   = cnt_width(NDATA);
    localparam logic [CW-1:0]  LAST = CW'(NDATA - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          frame_valid_q, frame_valid_d;
    logic          overrun_q, overrun_d;

    logic sync_tick;
    logic sync_clr;
    logic sync_match;

    // Sync matching only runs while hunting.
    assign sync_tick = bit_tick && (state_q == HUNT);

    sync_detect #(
        .SYNC_W    (SYNC_W),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .tick  (sync_tick),
        .clr   (sync_clr),
        .match (sync_match)
    );

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        frame_valid_d = frame_valid_q;
        overrun_d     = overrun_q;
        shift_ena     = 1'b0;
        capture       = 1'b0;
        sync_clr      = 1'b0;

        if (frame_valid_q && frame_ack) begin
            frame_valid_d = 1'b0;
        end
        if (clr_ovr) begin
            overrun_d = 1'b0;
        end

        unique case (state_q)
            HUNT: begin
                bit_cnt_d = '0;
                if (sync_match) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                shift_ena = bit_tick;
                if (bit_tick) begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d   = HUNT;
                bit_cnt_d = '0;
                sync_clr  = 1'b1;
                // An ack landing this cycle frees the slot for the new frame;
                // the set below overrides both the ack clear and clr_ovr.
                if (!frame_valid_q || frame_ack) begin
                    capture       = 1'b1;
                    frame_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d   = HUNT;
                bit_cnt_d = '0;
                sync_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            bit_cnt_q     <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign busy        = (state_q == RECV);
    assign frame_valid = frame_valid_q;
    assign overrun     = overrun_q;
    assign bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed bench for serial_frame_ctrl: expected payloads queue on send and
// are checked against an external shift buffer whenever capture fires.
module tb_serial_frame_ctrl;

  localparam int NDATA = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       din, bit_tick, frame_ack, clr_ovr;
  logic       shift_ena, capture, frame_valid, overrun, busy;
  logic [7:0] bit_cnt;

  logic       din_b, tick_b;
  logic       ack_b, clr_b;
  logic       shift_ena_b, capture_b, frame_valid_b, overrun_b, busy_b;
  logic [2:0] bit_cnt_b;

  int n_cmp = 0;
  int n_err = 0;
  int n_capt = 0;
  int shifts = 0;
  logic prev_shift = 1'b0;
  logic done_flag = 1'b0;

  logic [NDATA-1:0] sbuf = '0;
  logic [NDATA-1:0] exp_q[$];

  always #5 clk = ~clk;

  serial_frame_ctrl #(.NDATA(NDATA)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .bit_tick    (bit_tick),
    .frame_ack   (frame_ack),
    .clr_ovr     (clr_ovr),
    .shift_ena   (shift_ena),
    .capture     (capture),
    .frame_valid (frame_valid),
    .overrun     (overrun),
    .busy        (busy),
    .bit_cnt     (bit_cnt)
  );

  serial_frame_ctrl #(.NDATA(4), .SYNC_WORD(8'hAA)) dut_aa (
    .clk         (clk),
    .rst         (rst),
    .din         (din_b),
    .bit_tick    (tick_b),
    .frame_ack   (ack_b),
    .clr_ovr     (clr_b),
    .shift_ena   (shift_ena_b),
    .capture     (capture_b),
    .frame_valid (frame_valid_b),
    .overrun     (overrun_b),
    .busy        (busy_b),
    .bit_cnt     (bit_cnt_b)
  );

  task automatic chk(input string tag, input logic [NDATA-1:0] obs,
                     input logic [NDATA-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    if (!done_flag) begin
      n_err++;
      $error("FAIL timeout: sequence did not complete within the wait limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  always @(posedge clk) begin
    if (shift_ena) sbuf <= {sbuf[NDATA-2:0], din};
  end

  always @(negedge clk) begin
    if (capture === 1'b1) begin
      n_capt++;
      chk("capture_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        logic [NDATA-1:0] e;
        e = exp_q.pop_front();
        chk("frame_data", sbuf, e);
      end
      chk("shift_count", shifts, NDATA);
      chk("capture_latency", prev_shift, 1'b1);
    end
    prev_shift = shift_ena;
    if (busy !== 1'b1) shifts = 0;
    else if (shift_ena === 1'b1) shifts++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    din = b;
    bit_tick = 1'b1;
    @(posedge clk);
    #1;
    bit_tick = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      idle(3);
    end
  endtask

  task automatic send_frame(input logic [NDATA-1:0] p, input logic ack_done,
                            input logic clr_done, input logic exp_cap,
                            input logic exp_ovr);
    logic [7:0] sw;
    sw = 8'hA5;
    if (exp_cap) exp_q.push_back(p);
    for (int i = 7; i >= 1; i--) begin
      send_bit(sw[i]);
      idle(3);
    end
    @(negedge clk);
    chk("pre_sync_busy", busy, 1'b0);
    send_bit(sw[0]);
    @(negedge clk);
    chk("sync_busy", busy, 1'b1);
    chk("sync_bit_cnt", bit_cnt, 8'd0);
    idle(3);
    for (int i = NDATA - 1; i >= 0; i--) begin
      send_bit(p[i]);
      if (i == 64) begin
        @(negedge clk);
        chk("mid_bit_cnt", bit_cnt, 8'd64);
      end
      if (i != 0) idle(3);
    end
    // DONE cycle: a stray tick here must be ignored.
    frame_ack = ack_done;
    clr_ovr = clr_done;
    din = 1'b1;
    bit_tick = 1'b1;
    @(negedge clk);
    chk("done_capture", capture, exp_cap);
    chk("done_shift_ena", shift_ena, 1'b0);
    chk("done_bit_cnt", bit_cnt, 8'd128);
    chk("done_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
    clr_ovr = 1'b0;
    bit_tick = 1'b0;
    @(negedge clk);
    chk("post_frame_valid", frame_valid, 1'b1);
    chk("post_overrun", overrun, exp_ovr);
    chk("post_bit_cnt", bit_cnt, 8'd0);
    chk("post_busy", busy, 1'b0);
    idle(2);
  endtask

  task automatic send_bit_b(input logic b);
    din_b = b;
    tick_b = 1'b1;
    @(posedge clk);
    #1;
    tick_b = 1'b0;
    idle(3);
  endtask

  function automatic logic [NDATA-1:0] rand_payload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    din = 1'b0; bit_tick = 1'b0; frame_ack = 1'b0; clr_ovr = 1'b0;
    din_b = 1'b0; tick_b = 1'b0; ack_b = 1'b0; clr_b = 1'b0;
    rst = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_shift_ena", shift_ena, 1'b0);
    chk("rst_capture", capture, 1'b0);
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bit_cnt", bit_cnt, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Basic frame
    send_frame(rand_payload(), 1'b0, 1'b0, 1'b1, 1'b0);

    // Handshake: ack clears, ack while idle is ignored
    frame_ack = 1'b1;
    idle(1);
    frame_ack = 1'b0;
    @(negedge clk);
    chk("ack_clears_valid", frame_valid, 1'b0);
    idle(1);
    frame_ack = 1'b1;
    idle(1);
    frame_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_valid", frame_valid, 1'b0);
    chk("idle_ack_overrun", overrun, 1'b0);
    idle(1);

    // False sync candidates before the real one
    send_byte(8'hA4);
    @(negedge clk);
    chk("false_a4_busy", busy, 1'b0);
    send_byte(8'h5A);
    @(negedge clk);
    chk("false_5a_busy", busy, 1'b0);
    idle(1);
    send_frame(rand_payload(), 1'b0, 1'b0, 1'b1, 1'b0);
    chk("false_sync_captures", n_capt, 2);
    frame_ack = 1'b1;
    idle(1);
    frame_ack = 1'b0;
    @(negedge clk);
    chk("ack2_clears_valid", frame_valid, 1'b0);
    idle(1);

    // Overrun sequence
    send_frame(rand_payload(), 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(rand_payload(), 1'b0, 1'b0, 1'b0, 1'b1);
    clr_ovr = 1'b1;
    idle(1);
    clr_ovr = 1'b0;
    @(negedge clk);
    chk("clr_ovr_clears", overrun, 1'b0);
    chk("clr_ovr_valid_kept", frame_valid, 1'b1);
    idle(1);
    send_frame(rand_payload(), 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(rand_payload(), 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset mid-frame (frame_valid and overrun are both set here)
    send_byte(8'hA5);
    for (int i = 0; i < 60; i++) begin
      send_bit(1'($urandom));
      idle(3);
    end
    @(negedge clk);
    chk("pre_rst_bit_cnt", bit_cnt, 8'd60);
    din = 1'b1;
    bit_tick = 1'b1;
    #1;
    chk("pre_rst_shift_ena", shift_ena, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_shift_ena", shift_ena, 1'b0);
    chk("async_rst_capture", capture, 1'b0);
    chk("async_rst_valid", frame_valid, 1'b0);
    chk("async_rst_overrun", overrun, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_bit_cnt", bit_cnt, 8'd0);
    bit_tick = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    send_frame(rand_payload(), 1'b0, 1'b0, 1'b1, 1'b0);

    // Overlapping sync on the AA instance: 0101_0101_0
    for (int i = 0; i < 8; i++) send_bit_b(1'(i & 1));
    @(negedge clk);
    chk("aa_no_early_match", busy_b, 1'b0);
    send_bit_b(1'b0);
    @(negedge clk);
    chk("aa_match_busy", busy_b, 1'b1);
    chk("aa_match_bit_cnt", bit_cnt_b, 3'd0);
    din_b = 1'b1;
    tick_b = 1'b1;
    #1;
    chk("aa_shift_ena_comb", shift_ena_b, 1'b1);
    @(posedge clk);
    #1;
    tick_b = 1'b0;
    idle(3);
    send_bit_b(1'b0);
    send_bit_b(1'b1);
    din_b = 1'b1;
    tick_b = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("aa_done_capture", capture_b, 1'b1);
    chk("aa_done_shift_ena", shift_ena_b, 1'b0);
    chk("aa_done_bit_cnt", bit_cnt_b, 3'd4);
    @(posedge clk);
    #1;
    tick_b = 1'b0;
    @(negedge clk);
    chk("aa_post_valid", frame_valid_b, 1'b1);
    chk("aa_post_busy", busy_b, 1'b0);
    chk("aa_post_bit_cnt", bit_cnt_b, 3'd0);

    idle(2);
    chk("capture_count", n_capt, 5);
    chk("scoreboard_empty", exp_q.size(), 0);

    done_flag = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
